switch_debounce_8ch: RTL

- Conditions 8 raw asynchronous slide-switch/button inputs into a clean, synchronous 8-bit vector.
- The output drives the priority encoder input `r` directly.
- Provides per-bit rise/fall strobes and an any-change strobe, so downstream logic (encoder plus display latch) updates only on real transitions.
- Sits between the board I/O pins and the 8-to-3 encoder stage.

---
 rtl/switch_debounce_8ch.sv | 98 +++++++++
 1 files changed

// File: rtl/switch_debounce_8ch.sv
// switch_debounce_8ch: two-flop synchronizer, shared sample prescaler and
// per-channel stability counters that turn raw switch levels into clean edges.
module switch_debounce_8ch #(
    parameter int           N          = 8,
    parameter int           TICK_DIV   = 50000,
    parameter int           STABLE_CNT = 4,
    parameter logic [N-1:0] RESET_VAL  = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw_in,
    output logic [N-1:0] db_out,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         changed,
    output logic         tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_CNT + 1);

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic [N-1:0]  r_sync1;
    logic [N-1:0]  r_sync2;
    logic [PW-1:0] r_pre;
    logic [CW-1:0] r_cnt [N];

    logic          w_pre_wrap;
    logic [N-1:0]  w_hit;

    assign w_pre_wrap = (r_pre == PRE_LAST);

    // Bring the asynchronous pins into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
        end
    end

    // Divide clk down to a one-cycle sample strobe every TICK_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= w_pre_wrap;
            if (w_pre_wrap) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + PW'(1);
            end
        end
    end

    // Channels whose new level has now been seen on enough consecutive ticks.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < N; i++) begin
            w_hit[i] = tick
                     && (r_sync2[i] != db_out[i])
                     && (r_cnt[i] == CNT_LAST);
        end
    end

    // Advance stability counters on ticks and commit accepted levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_out  <= RESET_VAL;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            rise    <= w_hit & r_sync2;
            fall    <= w_hit & ~r_sync2;
            changed <= |w_hit;
            if (tick) begin
                db_out <= (db_out & ~w_hit) | (r_sync2 & w_hit);
                for (int i = 0; i < N; i++) begin
                    if ((r_sync2[i] == db_out[i]) || w_hit[i]) begin
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

endmodule
